// File: rtl/line_fill_arbiter_if.sv
// Bundle of the I-side, D-side and memory-side signals of the line-fill arbiter.
// The arbiter connects through the slave modport; the requesters and memory connect through master.
interface line_fill_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    localparam int LINE_W = DATA_W * BEATS;

    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_fill_valid;

    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_ready;
    logic              d_fill_valid;

    logic [LINE_W-1:0] fill_line;
    logic [ADDR_W-1:0] fill_addr;

    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              busy;
    logic              err;

    modport slave (
        input  i_req_valid, i_req_addr, d_req_valid, d_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output i_req_ready, i_fill_valid, d_req_ready, d_fill_valid,
        output fill_line, fill_addr, mem_req_valid, mem_req_addr, busy, err
    );

    modport master (
        output i_req_valid, i_req_addr, d_req_valid, d_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  i_req_ready, i_fill_valid, d_req_ready, d_fill_valid,
        input  fill_line, fill_addr, mem_req_valid, mem_req_addr, busy, err
    );
endinterface

// File: rtl/line_fill_arbiter.sv
// Round-robin sharing of one memory read port between I-cache and D-cache line fills:
// issues the line command, gathers BEATS beats into one line and pulses the owner's fill_valid.
module line_fill_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input logic                clk,
    input logic                rst,
    line_fill_arbiter_if.slave bus
);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_i_q, owner_i_d;
    logic              last_i_q, last_i_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              i_fill_q, i_fill_d;
    logic              d_fill_q, d_fill_d;
    logic              err_q, err_d;

    logic              sel_i;
    logic              i_rdy;
    logic              d_rdy;
    logic [ADDR_W-1:0] req_addr;

    // Ready is combinational, so it is also gated by rst to stay low while reset is held.
    always_comb begin
        sel_i    = bus.i_req_valid && (!bus.d_req_valid || !last_i_q);
        i_rdy    = (state_q == S_IDLE) && rst && sel_i;
        d_rdy    = (state_q == S_IDLE) && rst && bus.d_req_valid && !sel_i;
        req_addr = i_rdy ? bus.i_req_addr : bus.d_req_addr;
    end

    always_comb begin
        state_d   = state_q;
        owner_i_d = owner_i_q;
        last_i_d  = last_i_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        i_fill_d  = 1'b0;
        d_fill_d  = 1'b0;
        err_d     = err_q;

        if (bus.mem_rsp_valid && (state_q != S_DATA)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_rdy || d_rdy) begin
                    owner_i_d = i_rdy;
                    last_i_d  = i_rdy;
                    addr_d    = req_addr & LINE_MASK;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.mem_rsp_valid) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*DATA_W +: DATA_W] = bus.mem_rsp_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    // Fill pulse is registered here so it lands exactly on the DONE cycle.
                    if (cnt_q == LAST_BEAT) begin
                        i_fill_d = owner_i_q;
                        d_fill_d = !owner_i_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_i_q <= 1'b0;
            last_i_q  <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            line_q    <= '0;
            i_fill_q  <= 1'b0;
            d_fill_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_i_q <= owner_i_d;
            last_i_q  <= last_i_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            i_fill_q  <= i_fill_d;
            d_fill_q  <= d_fill_d;
            err_q     <= err_d;
        end
    end

    assign bus.i_req_ready   = i_rdy;
    assign bus.d_req_ready   = d_rdy;
    assign bus.i_fill_valid  = i_fill_q;
    assign bus.d_fill_valid  = d_fill_q;
    assign bus.fill_line     = line_q;
    assign bus.fill_addr     = addr_q;
    assign bus.mem_req_valid = (state_q == S_CMD);
    assign bus.mem_req_addr  = addr_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.err           = err_q;
endmodule
